// File: rtl/bpa_word_packer_if.sv
// Word-in / frame-out handshake bundle for the shift-word packer.
// slave is the packer's view; master is the surrounding logic's view.
interface bpa_word_packer_if #(
    parameter int WORD_W = 10,
    parameter int NWORDS = 48
);
    localparam int FRAME_W = WORD_W * NWORDS;
    localparam int CNT_W   = $clog2(NWORDS + 1);

    logic               in_valid;
    logic               in_ready;
    logic [WORD_W-1:0]  in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [FRAME_W-1:0] out_data;
    logic [CNT_W-1:0]   out_count;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/bpa_word_packer.sv
// Packs NWORDS shift words into one frame for the shift combiner's b input.
// Early close via in_last leaves the unfilled slots zero (no-op shifts downstream).
module bpa_word_packer #(
    parameter int WORD_W = 10,
    parameter int NWORDS = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    bpa_word_packer_if.slave bus
);
    localparam int FRAME_W = WORD_W * NWORDS;
    localparam int CNT_W   = $clog2(NWORDS + 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t             state, state_n;
    logic [FRAME_W-1:0] collect, collect_n, merged, load_data;
    logic [CNT_W-1:0]   wptr, wptr_n, load_cnt;
    logic               accept, close, slot_free, load;

    // Gating with rst_n keeps in_ready low during reset; out_ready never reaches it.
    assign bus.in_ready = rst_n && (state == FILL);
    assign accept       = bus.in_valid && bus.in_ready;
    assign close        = accept && (bus.in_last || wptr == CNT_W'(NWORDS - 1));
    assign slot_free    = !bus.out_valid || bus.out_ready;

    always_comb begin
        merged = collect;
        for (int k = 0; k < NWORDS; k++) begin
            if (wptr == CNT_W'(k))
                merged[k*WORD_W +: WORD_W] = bus.in_data;
        end
    end

    always_comb begin
        state_n   = state;
        collect_n = collect;
        wptr_n    = wptr;
        load      = 1'b0;
        load_data = merged;
        load_cnt  = wptr + CNT_W'(1);
        unique case (state)
            FILL: begin
                if (accept) begin
                    if (close && slot_free) begin
                        load      = 1'b1;
                        collect_n = '0;
                        wptr_n    = '0;
                    end else begin
                        // In HOLD, wptr carries the word count of the parked frame.
                        collect_n = merged;
                        wptr_n    = wptr + CNT_W'(1);
                        if (close)
                            state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = collect;
                    load_cnt  = wptr;
                    collect_n = '0;
                    wptr_n    = '0;
                    state_n   = FILL;
                end
            end
            default: state_n = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FILL;
            collect <= '0;
            wptr    <= '0;
        end else begin
            state   <= state_n;
            collect <= collect_n;
            wptr    <= wptr_n;
        end
    end

    // Data and count only move on a load, so they hold while the frame waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_count <= '0;
        end else if (load) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= load_data;
            bus.out_count <= load_cnt;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: doc/bpa_word_packer.md
# bpa_word_packer

Upstream packing stage for the blocking-procedural-assignment shift combiner. Accepts a stream of 10-bit shift words over a valid/ready handshake and packs 48 of them into one 480-bit frame, word k at bits [k*10+9:k*10]. It presents the frame on a registered valid/ready output that drives the combiner's `b` input directly. The block supports early frame termination with zero padding; a zero word is a no-op for the downstream combiner.

## Interface
- `WORD_W`, 10, width of one shift word.
- `NWORDS`, 48, words per frame; frame width is `WORD_W*NWORDS` (480).
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: upstream word valid.
- `in_ready` output 1: block can accept a word this cycle.
- `in_data` input WORD_W: shift word.
- `in_last` input 1: qualified by `in_valid`; the word being accepted closes the frame early.
- `out_valid` output 1: `out_data` holds a complete frame.
- `out_ready` input 1: downstream accepts the frame.
- `out_data` output WORD_W*NWORDS: packed frame; unfilled word slots are zero.
- `out_count` output 6: number of words loaded in the frame, 1..48.

## Operation
- **Collect buffer:** 480-bit register, write pointer `wptr` 0..47, and an output register holding `out_data`, `out_count` and `out_valid`.
- **Accept:** a word is accepted when `in_valid && in_ready`. It is written to `collect[wptr*10+:10]` and `wptr` increments.
- **Frame close:** the frame closes when an accepted word has `wptr==47` or `in_last==1`.
- **Output slot free:** the slot is free when `out_valid==0 || out_ready==1`.
- **State FILL:** `in_ready=1`.
  - On frame close with the slot free, the merged frame (collect buffer plus the current word) loads the output register on the same edge.
    - `out_count` = `wptr+1`.
    - The collect buffer clears to 0 and `wptr` returns to 0.
    - The state stays FILL.
  - On frame close with the slot not free, the current word is written into the collect buffer, `wptr` holds the count, and the state goes to HOLD.
- **State HOLD:** `in_ready=0`.
  - When the slot is free, the collect buffer moves to the output register with `out_count`=stored count.
  - The collect buffer clears, `wptr` returns to 0, and the state goes to FILL.
- **Output handshake:** `out_valid` drops after the `out_valid && out_ready` edge, unless a new frame loads on that same edge, in which case it stays 1.
- **Output stability:** `out_data` and `out_count` stay stable while `out_valid && !out_ready`.
- **`in_last` on a 48th word:** identical to a normal full close.
- **`in_last` with `in_valid==0`:** ignored.
- **Reset values:** `in_ready=0` while `rst_n` is low. After release:
  - `in_ready=1`, `out_valid=0`, `out_data=0`, `out_count=0`;
  - collect buffer 0, `wptr=0`, state FILL.
- **Reset mid-frame:** the partial frame and any pending output are discarded, with no output event.

## Timing
- **Latency:** from acceptance of the closing word (edge n) to `out_valid` is 1 cycle when the slot is free; `out_valid` is high in cycle n+1.
- **Throughput:** with `out_ready` held at 1, the block sustains one word per cycle with no bubbles. A frame is emitted every 48 cycles for full frames and every k cycles for k-word frames.
- **HOLD exit:**
  - HOLD is entered on edge n.
  - The transfer happens on the first edge m>n at which the slot is free.
  - `in_ready` returns to 1 in cycle m+1.
- **Combinational dependence:** `in_ready` depends only on state; there is no combinational path from `out_ready` to `in_ready`.
- **Backpressure:** `in_valid`, `in_data` and `in_last` may change freely while `in_ready==0`; nothing is sampled then.

## Test plan
- **Full frames:** stream 48 words with `in_data=k` for k=0..47 and `out_ready=1`. Expect `out_valid` exactly one cycle after word 47 is accepted, `out_data[k*10+:10]==k`, and `out_count==48`. Continue with 96 back-to-back words: expect 2 frames 48 cycles apart and `in_ready` constantly 1.
- **Short frame:** send 5 words 0x3FF with `in_last` on the 5th. Expect `out_count==5`, bits [49:0] all ones, bits [479:50] zero. The next frame starts at slot 0.
- **Backpressure into HOLD:**
  - Hold `out_ready=0`. Expect frame A presented and stable, then frame B filling to 48 words.
  - After frame B completes, `in_ready` must fall in the cycle after B's closing word.
  - Raise `out_ready` for 1 cycle. Expect A consumed and B presented on the same edge, and `in_ready=1` one cycle later.
- **Single-word frames:** send 3 words, each with `in_last` and `out_ready=1`. Expect 3 consecutive frames with `out_count==1` and only slot 0 nonzero.
- **Reset mid-frame:** assert `rst_n=0` asynchronously after 20 words are accepted. Expect all outputs at reset values immediately. After release, a full 48-word frame emits with no residue from the 20 discarded words.
- **End-to-end with the combiner:** feed words all 1, `NWORDS=48`, into the downstream combiner. The combiner output equals `'0` shifted 48 times, i.e. 0. With the first word 0 and the rest padded by `in_last`, the output is 0 and unchanged.
